// File: rtl/ex_stage_pkg.sv
// Shared encodings, widths and helpers for the MIPS execute stage.
// Holds ALU ops, forward selects, multiplier FSM states and the EX/MEM register layout.
package ex_stage_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic          regwrite;
    logic          memtoreg;
    logic          memwrite;
    logic [DW-1:0] aluout;
    logic [DW-1:0] writedata;
    logic [RW-1:0] writereg;
  } exmem_t;

  function automatic logic [DW-1:0] fwd_sel(input logic [1:0]    sel,
                                            input logic [DW-1:0] rf,
                                            input logic [DW-1:0] wb,
                                            input logic [DW-1:0] mem);
    case (sel)
      FWD_WB:  fwd_sel = wb;
      FWD_MEM: fwd_sel = mem;
      default: fwd_sel = rf;
    endcase
  endfunction

  function automatic logic [DW-1:0] alu_eval(input logic [2:0]    op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    case (op)
      ALU_ADD: alu_eval = a + b;
      ALU_SUB: alu_eval = a - b;
      ALU_AND: alu_eval = a & b;
      ALU_OR:  alu_eval = a | b;
      ALU_SLT: alu_eval = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_eval = '0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, writeback forward source and EX/MEM outputs of the execute stage.
// slave is the execute stage's view; master is the surrounding pipeline's view.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic          regwrite_E;
  logic          memtoreg_E;
  logic          memwrite_E;
  logic [2:0]    alucontrol_E;
  logic          alusrc_E;
  logic          regdst_E;
  logic          mul_E;
  logic [DW-1:0] rd1_E;
  logic [DW-1:0] rd2_E;
  logic [RW-1:0] rt_E;
  logic [RW-1:0] rd_E;
  logic [DW-1:0] SignImm_E;
  logic [1:0]    forwardA_E;
  logic [1:0]    forwardB_E;
  logic [DW-1:0] result_W;

  logic [RW-1:0] writereg_E;
  logic          stall_E;
  logic          regwrite_M;
  logic          memtoreg_M;
  logic          memwrite_M;
  logic [DW-1:0] aluout_M;
  logic [DW-1:0] writedata_M;
  logic [RW-1:0] writereg_M;

  modport slave (
    input  regwrite_E, memtoreg_E, memwrite_E, alucontrol_E, alusrc_E, regdst_E, mul_E,
    input  rd1_E, rd2_E, rt_E, rd_E, SignImm_E, forwardA_E, forwardB_E, result_W,
    output writereg_E, stall_E, regwrite_M, memtoreg_M, memwrite_M,
    output aluout_M, writedata_M, writereg_M
  );

  modport master (
    output regwrite_E, memtoreg_E, memwrite_E, alucontrol_E, alusrc_E, regdst_E, mul_E,
    output rd1_E, rd2_E, rt_E, rd_E, SignImm_E, forwardA_E, forwardB_E, result_W,
    input  writereg_E, stall_E, regwrite_M, memtoreg_M, memwrite_M,
    input  aluout_M, writedata_M, writereg_M
  );

endinterface

// File: rtl/ex_stage_mul_seq.sv
// Sequential 32x32 shift-add multiplier (low 32 bits), one multiplier bit per BUSY cycle.
// stall is high in IDLE when a MUL is presented and throughout BUSY; done marks the result cycle.
module mul_seq
  import ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] mcand_in,
  input  logic [DW-1:0] mplier_in,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] product
);

  mul_state_t    state, state_nxt;
  logic [4:0]    count;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [DW-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MUL_IDLE;
    else        state <= state_nxt;
  end

  // DONE always returns to IDLE so a MUL still sitting in ID/EX is not re-issued.
  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start)        state_nxt = MUL_BUSY;
      MUL_BUSY: if (count == 5'd31) state_nxt = MUL_DONE;
      MUL_DONE:                   state_nxt = MUL_IDLE;
      default:                    state_nxt = MUL_IDLE;
    endcase
  end

  // Gated by rst_n so the front end is released the moment reset asserts.
  always_comb begin
    stall = rst_n && (((state == MUL_IDLE) && start) || (state == MUL_BUSY));
    done  = (state == MUL_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand  <= mcand_in;
            mplier <= mplier_in;
            acc    <= '0;
            count  <= '0;
          end
        end
        MUL_BUSY: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding muxes, ALU, write-register select, multiplier and the EX/MEM register.
// EX/MEM takes a bubble on every edge while the multiplier stalls the front end.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ex_stage_if.slave  bus
);

  logic [DW-1:0] src_a;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] src_b;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] product;
  logic          stall;
  logic          done;
  exmem_t        exmem_d;
  exmem_t        exmem_q;

  always_comb begin
    src_a = fwd_sel(bus.forwardA_E, bus.rd1_E, bus.result_W, bus.aluout_M);
    fwd_b = fwd_sel(bus.forwardB_E, bus.rd2_E, bus.result_W, bus.aluout_M);
    src_b = bus.alusrc_E ? bus.SignImm_E : fwd_b;
    alu_y = alu_eval(bus.alucontrol_E, src_a, src_b);
  end

  // The multiplier always consumes the forwarded register operand, never the immediate.
  mul_seq u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (bus.mul_E),
    .mcand_in  (src_a),
    .mplier_in (fwd_b),
    .stall     (stall),
    .done      (done),
    .product   (product)
  );

  assign bus.writereg_E = bus.regdst_E ? bus.rd_E : bus.rt_E;
  assign bus.stall_E    = stall;

  always_comb begin
    exmem_d = '0;
    if (!stall) begin
      exmem_d.regwrite  = bus.regwrite_E;
      exmem_d.memtoreg  = bus.memtoreg_E;
      exmem_d.memwrite  = bus.memwrite_E;
      exmem_d.aluout    = done ? product : alu_y;
      exmem_d.writedata = fwd_b;
      exmem_d.writereg  = bus.writereg_E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exmem_q <= '0;
    else        exmem_q <= exmem_d;
  end

  assign bus.regwrite_M  = exmem_q.regwrite;
  assign bus.memtoreg_M  = exmem_q.memtoreg;
  assign bus.memwrite_M  = exmem_q.memwrite;
  assign bus.aluout_M    = exmem_q.aluout;
  assign bus.writedata_M = exmem_q.writedata;
  assign bus.writereg_M  = exmem_q.writereg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, regdst, store data, multiplier stalls and reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   n_stall;
  int   n_bad;

  ex_stage_if bus ();

  ex_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    bus.regwrite_E   = 1'b0;
    bus.memtoreg_E   = 1'b0;
    bus.memwrite_E   = 1'b0;
    bus.alucontrol_E = 3'b000;
    bus.alusrc_E     = 1'b0;
    bus.regdst_E     = 1'b0;
    bus.mul_E        = 1'b0;
    bus.rd1_E        = '0;
    bus.rd2_E        = '0;
    bus.rt_E         = '0;
    bus.rd_E         = '0;
    bus.SignImm_E    = '0;
    bus.forwardA_E   = FWD_RF;
    bus.forwardB_E   = FWD_RF;
    bus.result_W     = '0;
  endtask

  // Counts cycles with stall_E high (bounded) and bubbles that leak control bits.
  task automatic run_mul(input int poke_at, output int n, output int bad);
    n   = 0;
    bad = 0;
    for (int i = 0; i < 100 && bus.stall_E; i++) begin
      n++;
      if (n > 1 && (bus.regwrite_M || bus.memwrite_M || bus.memtoreg_M)) bad++;
      if (i == poke_at) bus.result_W = 32'd100;
      tick();
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b0;
    checks   = 0;
    failures = 0;
    clear_ins();
    repeat (3) tick();

    chk("rst_aluout",   bus.aluout_M, 32'd0);
    chk("rst_regwrite", 32'(bus.regwrite_M), 32'd0);
    chk("rst_writereg", 32'(bus.writereg_M), 32'd0);
    chk("rst_stall",    32'(bus.stall_E), 32'd0);
    rst_n = 1'b1;

    // Forwarding: seed aluout_M with 7, then select each source.
    bus.rd1_E = 32'd7; bus.alusrc_E = 1'b1; bus.SignImm_E = 32'd0;
    bus.alucontrol_E = ALU_ADD; bus.regwrite_E = 1'b1;
    tick();
    chk("seed_aluout", bus.aluout_M, 32'd7);
    bus.rd1_E = 32'd5; bus.result_W = 32'd9; bus.SignImm_E = 32'd1;
    bus.forwardA_E = FWD_MEM;
    tick();
    chk("fwd_mem", bus.aluout_M, 32'd8);
    bus.forwardA_E = FWD_WB;
    tick();
    chk("fwd_wb", bus.aluout_M, 32'd10);
    bus.forwardA_E = FWD_RF;
    tick();
    chk("fwd_rf", bus.aluout_M, 32'd6);

    // ALU ops.
    bus.rd1_E = 32'h8000_0000; bus.SignImm_E = 32'd1; bus.alucontrol_E = ALU_SLT;
    tick();
    chk("slt_neg", bus.aluout_M, 32'd1);
    bus.rd1_E = 32'hFFFF_FFFF; bus.alucontrol_E = ALU_ADD;
    tick();
    chk("add_wrap", bus.aluout_M, 32'd0);
    bus.alusrc_E = 1'b0; bus.rd1_E = 32'd3; bus.rd2_E = 32'd5; bus.alucontrol_E = ALU_SUB;
    tick();
    chk("sub_neg", bus.aluout_M, 32'hFFFF_FFFE);
    bus.alucontrol_E = 3'b011;
    tick();
    chk("op_unused", bus.aluout_M, 32'd0);
    bus.rd1_E = 32'h0000_00F0; bus.rd2_E = 32'h0000_003C; bus.alucontrol_E = ALU_AND;
    tick();
    chk("and", bus.aluout_M, 32'h0000_0030);
    bus.alucontrol_E = ALU_OR;
    tick();
    chk("or", bus.aluout_M, 32'h0000_00FC);

    // Write-register select.
    bus.regdst_E = 1'b1; bus.rd_E = 5'd12; bus.rt_E = 5'd3;
    #1;
    chk("wreg_E_rd", 32'(bus.writereg_E), 32'd12);
    tick();
    chk("wreg_M_rd", 32'(bus.writereg_M), 32'd12);
    bus.regdst_E = 1'b0;
    #1;
    chk("wreg_E_rt", 32'(bus.writereg_E), 32'd3);
    tick();
    chk("wreg_M_rt", 32'(bus.writereg_M), 32'd3);

    // Store data is forwarded SrcB ahead of the immediate mux.
    bus.regwrite_E = 1'b0; bus.memwrite_E = 1'b1; bus.forwardB_E = FWD_WB;
    bus.result_W = 32'h0000_1234; bus.rd2_E = 32'd55; bus.alusrc_E = 1'b1; bus.SignImm_E = 32'd77;
    tick();
    chk("store_data",     bus.writedata_M, 32'h0000_1234);
    chk("store_memwrite", 32'(bus.memwrite_M), 32'd1);
    chk("store_regwrite", 32'(bus.regwrite_M), 32'd0);

    // MUL 6*7 with A forwarded from writeback; result_W changes mid-stall.
    bus.memwrite_E = 1'b0; bus.regwrite_E = 1'b1; bus.regdst_E = 1'b1; bus.rd_E = 5'd8;
    bus.forwardA_E = FWD_WB; bus.result_W = 32'd6; bus.rd1_E = 32'd0;
    bus.forwardB_E = FWD_RF; bus.rd2_E = 32'd7; bus.alusrc_E = 1'b1; bus.SignImm_E = 32'd99;
    bus.alucontrol_E = ALU_ADD; bus.mul_E = 1'b1;
    #1;
    run_mul(5, n_stall, n_bad);
    chk("mul1_stall_cycles", 32'(n_stall), 32'd33);
    chk("mul1_bubbles",      32'(n_bad),   32'd0);
    tick();
    chk("mul1_result",   bus.aluout_M, 32'd42);
    chk("mul1_regwrite", 32'(bus.regwrite_M), 32'd1);
    chk("mul1_writereg", 32'(bus.writereg_M), 32'd8);
    bus.mul_E = 1'b0;

    // Back-to-back MULs: all-ones squared, then 3*5.
    bus.forwardA_E = FWD_RF; bus.rd1_E = 32'hFFFF_FFFF; bus.rd2_E = 32'hFFFF_FFFF;
    bus.mul_E = 1'b1;
    #1;
    run_mul(-1, n_stall, n_bad);
    chk("mul2_stall_cycles", 32'(n_stall), 32'd33);
    tick();
    chk("mul2_result", bus.aluout_M, 32'd1);
    bus.rd1_E = 32'd3; bus.rd2_E = 32'd5;
    #1;
    chk("mul3_restart", 32'(bus.stall_E), 32'd1);
    run_mul(-1, n_stall, n_bad);
    chk("mul3_stall_cycles", 32'(n_stall), 32'd33);
    chk("mul3_bubbles",      32'(n_bad),   32'd0);
    tick();
    chk("mul3_result", bus.aluout_M, 32'd15);
    bus.mul_E = 1'b0;

    // Reset at BUSY count=10, then a full MUL afterwards.
    bus.rd1_E = 32'd6; bus.rd2_E = 32'd7; bus.mul_E = 1'b1;
    #1;
    chk("mul4_start_stall", 32'(bus.stall_E), 32'd1);
    repeat (11) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall",     32'(bus.stall_E), 32'd0);
    chk("rstmid_aluout",    bus.aluout_M, 32'd0);
    chk("rstmid_regwrite",  32'(bus.regwrite_M), 32'd0);
    chk("rstmid_writedata", bus.writedata_M, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    run_mul(-1, n_stall, n_bad);
    chk("mul5_stall_cycles", 32'(n_stall), 32'd33);
    tick();
    chk("mul5_result", bus.aluout_M, 32'd42);
    bus.mul_E = 1'b0;
    tick();
    chk("idle_after_mul", 32'(bus.stall_E), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
